reg_req_encoder: RTL
====================

# reg_req_encoder

Registered 8-to-3 request encoder and arbiter for the register-file write port. It takes eight per-client request lines and selects one requester. The selected requester is returned as a 3-bit index with a valid/ready handshake toward the register file, where the index drives the write-address decoder. A one-cycle one-hot grant goes back to the selected client.

## Interface
Parameters:
- N, 8, number of requesters; must equal 2**AW
- AW, 3, index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- en  in  1  capture enable; when 0, no new request is captured
- req  in  N  request lines; any number may be high at once
- gnt  out  N  one-hot grant; high for exactly one cycle per capture
- out_valid  out  1  out_idx holds a captured, unaccepted request
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_idx  out  AW  binary index of the granted requester
- out_multi  out  1  more than one qualified request was active at capture

## Operation
- Reset values: out_valid=0, out_idx=0, out_multi=0, gnt=0, round-robin pointer ptr=0, state=IDLE.
- Qualified request vector: qreq = req & ~gnt. This masks the requester granted in the current cycle.
- States:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1, with out_idx and out_multi stable.
- Capture condition:
  - In IDLE: en && |qreq.
  - In HOLD: out_ready && en && |qreq (back-to-back capture).
- Capture action at the edge:
  - out_idx <= selected index.
  - gnt <= one-hot of the selected index.
  - out_multi <= (popcount(qreq) > 1).
  - Go to or stay in HOLD.
- Selection (round-robin): the first set bit of qreq scanning ptr, ptr+1, …, wrapping N-1→0.
- Pointer update:
  - On every capture, ptr <= selected index + 1, mod N. The value 7 wraps to 0.
  - The pointer changes only on capture.
- Transitions:
  - IDLE→HOLD on capture.
  - In HOLD with out_ready=0: stay, and ignore req entirely.
  - In HOLD with out_ready=1 and no capture: go to IDLE.
  - In HOLD with out_ready=1 and a capture: stay in HOLD with the new out_idx.
- gnt is 0 on every cycle not immediately following a capture edge.
- en=0 blocks capture only. It does not revoke a pending out_valid.
- Asynchronous reset in any state drops out_valid and gnt immediately. The held request is lost, and ptr returns to 0.

## Timing
- Latency: req sampled at edge k → out_valid, out_idx and gnt valid after edge k.
  - gnt is high for cycle k only.
- Throughput: one capture per cycle while out_ready=1 and qualified requests remain.
- Requesters must drop req on the cycle after seeing gnt. A req still high in the gnt cycle is masked for that cycle only.
- out_idx, out_multi and out_valid are register outputs with no combinational path from req.
- gnt is also a register output.
- out_ready → next-state path is combinational into registers only. No comb path from out_ready to any output.

## Configuration
- Macro REQ_ENC_FIXED_PRIO_EN.
- Defined: fixed priority, where the lowest set bit of qreq wins. ptr is not implemented and is treated as constant 0.
- Undefined (default): round-robin selection as described in Operation.
- All other behaviour, handshake and timing are identical in both builds.

## Test plan
- Reset with a pending request: assert rst mid-HOLD with out_idx=5.
  - out_valid=0 and gnt=0 immediately (before the next edge).
  - After release, a request on req=8'h02 yields out_idx=1.
- Single request with stall: req=8'h10 with out_ready=0 for 3 cycles.
  - gnt=8'h10 for one cycle, then out_idx=4 and out_valid=1 held 3 cycles.
  - Accepted on out_ready=1, then IDLE.
- Round-robin wrap: req=8'h81 held constant, out_ready=1, with each requester dropping req one cycle after its gnt.
  - Grant order is 0, then 7.
  - ptr wraps to 0, and a new req=8'h81 grants 0.
- Multi-hot flag: req=8'h2C from IDLE with ptr=0.
  - out_idx=2 and out_multi=1.
  - Single req=8'h40 then gives out_multi=0.
- Enable gating: en=0 with req=8'hFF.
  - out_valid stays 0 and gnt=0.
  - Raising en captures on the next edge.
- Fixed-priority build with REQ_ENC_FIXED_PRIO_EN: req=8'h81 repeated across 3 captures.
  - out_idx=0 every time, never 7.

Source files
------------

// File: rtl/reg_req_encoder.sv
// Registered 8-to-3 round-robin request encoder with valid/ready output and one-cycle grant.
// Define REQ_ENC_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rotating pointer).
module reg_req_encoder #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_idx,
    output logic          out_multi
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]    r_state;
    logic [N-1:0]  r_gnt;
    logic [AW-1:0] r_idx;
    logic          r_multi;

    logic [N-1:0]  w_qreq;
    logic          w_cap;
    logic [AW-1:0] w_ptr;
    logic [AW-1:0] w_cand;
    logic [AW-1:0] w_sel;
    logic          w_multi;

    // The requester granted this cycle is masked so a late-dropping req is not re-captured.
    assign w_qreq  = req & ~r_gnt;
    assign w_cap   = en && (|w_qreq) && ((r_state == IDLE) || out_ready);
    assign w_multi = |(w_qreq & (w_qreq - N'(1)));

`ifdef REQ_ENC_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [AW-1:0] r_ptr;

    assign w_ptr = r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_cap) begin
            r_ptr <= w_sel + AW'(1);
        end
    end
`endif

    // Scan from the farthest offset down so the offset closest to the pointer wins; N is a power of two so AW-bit addition wraps.
    always_comb begin
        w_sel  = '0;
        w_cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_cand = w_ptr + AW'(i);
            if (w_qreq[w_cand]) begin
                w_sel = w_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_multi <= 1'b0;
        end else begin
            if (w_cap) begin
                r_state <= HOLD;
                r_gnt   <= N'(1) << w_sel;
                r_idx   <= w_sel;
                r_multi <= w_multi;
            end else begin
                r_gnt <= '0;
                if ((r_state == HOLD) && out_ready) begin
                    r_state <= IDLE;
                end
            end
        end
    end

    assign gnt       = r_gnt;
    assign out_valid = (r_state == HOLD);
    assign out_idx   = r_idx;
    assign out_multi = r_multi;

endmodule
